vga_char_scanner: RTL

//  Display-side reader of the character buffer. Generates VGA raster timing
//  and walks the 8x8-glyph character grid in scan order. Drives the buffer's

---
 rtl/vga_timing_pkg.sv | 46 ++++
 rtl/vga_timing_gen.sv | 72 +++++++
 rtl/vga_char_scanner.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Default 640x480@60 raster constants, line/frame total helpers,
//            RGB444 pixel type and the shared pipeline flag bundle.
// Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  // Raster counters are kept at a fixed width wide enough for any legal mode.
  localparam int CNT_W = 12;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  // Both sync pins are active-low.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [11:0] rgb444_t;

  // Per-pixel raster flags carried alongside the buffer read.
  typedef struct packed {
    logic valid;
    logic active;
    logic in_grid;
    logic hs;
    logic vs;
    logic first;
  } pix_flags_t;

  function automatic int h_tot(input int act, input int front, input int sync, input int back);
    return act + front + sync + back;
  endfunction

  function automatic int v_tot(input int act, input int front, input int sync, input int back);
    return act + front + sync + back;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Horizontal/vertical raster counters with combinational decode of
//            sync levels and the active-video window.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int p_h_active = H_ACTIVE_DEF,
  parameter int p_h_front  = H_FRONT_DEF,
  parameter int p_h_sync   = H_SYNC_DEF,
  parameter int p_h_back   = H_BACK_DEF,
  parameter int p_v_active = V_ACTIVE_DEF,
  parameter int p_v_front  = V_FRONT_DEF,
  parameter int p_v_sync   = V_SYNC_DEF,
  parameter int p_v_back   = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             active_o
);

  localparam int H_TOT = h_tot(p_h_active, p_h_front, p_h_sync, p_h_back);
  localparam int V_TOT = v_tot(p_v_active, p_v_front, p_v_sync, p_v_back);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(p_h_active);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(p_v_active);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(p_h_active + p_h_front);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(p_h_active + p_h_front + p_h_sync);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(p_v_active + p_v_front);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(p_v_active + p_v_front + p_v_sync);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  // Next raster position: h wraps at end of line, v advances on each wrap.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Counter registers; reset parks the raster at (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o      = h_q;
  assign v_o      = v_q;
  assign hs_o     = ((h_q >= HS_START) && (h_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vs_o     = ((v_q >= VS_START) && (v_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign active_o = (h_q < H_ACT) && (v_q < V_ACT);

endmodule
`default_nettype wire

// File: rtl/vga_char_scanner.sv
`default_nettype none
// ============================================================================
// Module   : vga_char_scanner
// Purpose  : Walks the 8x8 character grid in raster order, addresses the
//            character buffer and turns returned glyph bits into RGB pixels
//            aligned with hsync/vsync.
// Revision : 1.0  initial release
// ============================================================================
module vga_char_scanner
  import vga_timing_pkg::*;
#(
  parameter int      p_num_rows     = 32,
  parameter int      p_num_cols     = 32,
  parameter int      p_h_active     = H_ACTIVE_DEF,
  parameter int      p_h_front      = H_FRONT_DEF,
  parameter int      p_h_sync       = H_SYNC_DEF,
  parameter int      p_h_back       = H_BACK_DEF,
  parameter int      p_v_active     = V_ACTIVE_DEF,
  parameter int      p_v_front      = V_FRONT_DEF,
  parameter int      p_v_sync       = V_SYNC_DEF,
  parameter int      p_v_back       = V_BACK_DEF,
  parameter int      p_read_latency = 0,
  parameter rgb444_t p_fg           = 12'hFFF,
  parameter rgb444_t p_bg           = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  read_hchar,
  output logic [5:0]  read_vchar,
  output logic [2:0]  read_hoffset,
  output logic [2:0]  read_voffset,
  input  logic        read_lit,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [11:0] vga_rgb,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] GRID_W = CNT_W'(p_num_cols * 8);
  localparam logic [CNT_W-1:0] GRID_H = CNT_W'(p_num_rows * 8);

  // Parameter range checks at elaboration.
  if ((p_num_rows < 1) || (p_num_rows > 64) || (p_num_rows * 8 > p_v_active)) begin : g_bad_rows
    $error("vga_char_scanner: p_num_rows out of range");
  end
  if ((p_num_cols < 1) || (p_num_cols > 128) || (p_num_cols * 8 > p_h_active)) begin : g_bad_cols
    $error("vga_char_scanner: p_num_cols out of range");
  end
  if ((p_read_latency != 0) && (p_read_latency != 1)) begin : g_bad_lat
    $error("vga_char_scanner: p_read_latency must be 0 or 1");
  end
  if ((h_tot(p_h_active, p_h_front, p_h_sync, p_h_back) > (1 << CNT_W)) ||
      (v_tot(p_v_active, p_v_front, p_v_sync, p_v_back) > (1 << CNT_W))) begin : g_bad_tot
    $error("vga_char_scanner: raster totals exceed counter width");
  end

  logic [CNT_W-1:0] h, v;
  logic             hs, vs, active;

  vga_timing_gen #(
    .p_h_active (p_h_active), .p_h_front (p_h_front),
    .p_h_sync   (p_h_sync),   .p_h_back  (p_h_back),
    .p_v_active (p_v_active), .p_v_front (p_v_front),
    .p_v_sync   (p_v_sync),   .p_v_back  (p_v_back)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .h_o      (h),
    .v_o      (v),
    .hs_o     (hs),
    .vs_o     (vs),
    .active_o (active)
  );

  // Address is {hchar,vchar,hoffset,voffset}.
  logic [18:0]  addr_q, addr_d;
  pix_flags_t   flags_q, flags_d;
  pix_flags_t   flags_al;
  logic         in_grid;

  // Stage 1 decode: grid address (zero outside the grid) and raster flags.
  always_comb begin
    in_grid = (h < GRID_W) && (v < GRID_H);
    addr_d  = in_grid ? {h[9:3], v[8:3], h[2:0], v[2:0]} : '0;
    flags_d = '{valid:   1'b1,
                active:  active,
                in_grid: in_grid,
                hs:      hs,
                vs:      vs,
                first:   (h == '0) && (v == '0)};
  end

  // Stage 1 registers drive the buffer address directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      flags_q <= '0;
    end else begin
      addr_q  <= addr_d;
      flags_q <= flags_d;
    end
  end

  assign read_hchar   = addr_q[18:12];
  assign read_vchar   = addr_q[11:6];
  assign read_hoffset = addr_q[5:3];
  assign read_voffset = addr_q[2:0];

  // Flags wait for the buffer so they meet read_lit in the same cycle.
  if (p_read_latency == 1) begin : g_lat1
    pix_flags_t flags_dly_q;
    // One-cycle flag delay matching a registered buffer read.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) flags_dly_q <= '0;
      else      flags_dly_q <= flags_q;
    end
    assign flags_al = flags_dly_q;
  end else begin : g_lat0
    assign flags_al = flags_q;
  end

  logic    hsync_q, hsync_d;
  logic    vsync_q, vsync_d;
  rgb444_t rgb_q, rgb_d;
  logic    fs_q, fs_d;

  // Stage 2 colour mapping; invalid slots present reset-level outputs.
  always_comb begin
    hsync_d = ~SYNC_ACTIVE;
    vsync_d = ~SYNC_ACTIVE;
    rgb_d   = '0;
    fs_d    = 1'b0;
    if (flags_al.valid) begin
      hsync_d = flags_al.hs;
      vsync_d = flags_al.vs;
      fs_d    = flags_al.first;
      if (!flags_al.active)                   rgb_d = '0;
      else if (flags_al.in_grid && read_lit)  rgb_d = p_fg;
      else                                    rgb_d = p_bg;
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
    end
  end

  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_rgb     = rgb_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire
